data_bus_arbiter: RTL

- Two-master arbiter sharing the single data bus that feeds DataMem and Peripheral.
- Master 0 is the CPU data port. Master 1 is a secondary requester, such as a UART/DMA engine.
- Uses round-robin arbitration with a bounded burst length, address-decodes each transfer to DataMem or Peripheral, and returns registered read data one cycle after the transfer.

---
 rtl/data_bus_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/data_bus_arbiter.sv
// Two-master round-robin data bus arbiter with bounded bursts.
// Ports: clk, reset (sync, active-low); m0_*/m1_* master request/grant/read-return
// sets; bus_addr/bus_wdata, mem_rd/mem_wr/mem_rdata, per_rd/per_wr/per_rdata
// slave side; owner (last granted master), busy (a master owns the bus).
module data_bus_arbiter #(
  parameter int unsigned BURST_MAX = 8,
  parameter logic [3:0]  PERI_SEL  = 4'b0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_wr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic [31:0] m0_rdata,
  output logic        m0_rvalid,
  input  logic        m1_req,
  input  logic        m1_wr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic [31:0] m1_rdata,
  output logic        m1_rvalid,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [31:0] mem_rdata,
  output logic        per_rd,
  output logic        per_wr,
  input  logic [31:0] per_rdata,
  output logic        owner,
  output logic        busy
);

  localparam logic [3:0] BMAX = 4'(BURST_MAX);

  typedef enum logic [1:0] {
    IDLE,
    OWN0,
    OWN1
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        last, last_nxt;
  logic        owner_nxt;
  logic        g0, g1, gnt, gi;
  logic        lim;
  logic        bus_wr;
  logic        sel_per;
  logic [31:0] rd_data;

  assign lim = (cnt == BMAX);

  // Holder keeps the bus unless the other side waits and the burst is spent.
  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (reset) begin
      unique case (state)
        OWN0: begin
          if (m0_req && !(m1_req && lim)) g0 = 1'b1;
          else if (m1_req) g1 = 1'b1;
        end
        OWN1: begin
          if (m1_req && !(m0_req && lim)) g1 = 1'b1;
          else if (m0_req) g0 = 1'b1;
        end
        default: begin
          if (m0_req && m1_req) begin
            g0 = last;
            g1 = !last;
          end else begin
            g0 = m0_req;
            g1 = m1_req;
          end
        end
      endcase
    end
  end

  assign gnt = g0 | g1;
  assign gi  = g1;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    last_nxt  = last;
    owner_nxt = owner;
    if (gnt) begin
      state_nxt = gi ? OWN1 : OWN0;
      last_nxt  = gi;
      owner_nxt = gi;
      if (gi == owner && state != IDLE)
        cnt_nxt = lim ? cnt : cnt + 4'd1;
      else
        cnt_nxt = 4'd1;
    end else begin
      state_nxt = IDLE;
      cnt_nxt   = 4'd0;
    end
  end

  assign m0_gnt    = g0;
  assign m1_gnt    = g1;
  assign bus_addr  = g1 ? m1_addr  : (g0 ? m0_addr  : 32'd0);
  assign bus_wdata = g1 ? m1_wdata : (g0 ? m0_wdata : 32'd0);
  assign bus_wr    = g1 ? m1_wr : (g0 & m0_wr);
  assign sel_per   = (bus_addr[31:28] == PERI_SEL);
  assign mem_rd    = gnt & !bus_wr & !sel_per;
  assign mem_wr    = gnt &  bus_wr & !sel_per;
  assign per_rd    = gnt & !bus_wr &  sel_per;
  assign per_wr    = gnt &  bus_wr &  sel_per;
  assign rd_data   = sel_per ? per_rdata : mem_rdata;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      last      <= 1'b1;
      owner     <= 1'b0;
      m0_rdata  <= 32'd0;
      m1_rdata  <= 32'd0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      last      <= last_nxt;
      owner     <= owner_nxt;
      m0_rvalid <= g0 & !m0_wr;
      m1_rvalid <= g1 & !m1_wr;
      if (g0 && !m0_wr) m0_rdata <= rd_data;
      if (g1 && !m1_wr) m1_rdata <= rd_data;
    end
  end

endmodule
